// File: rtl/gppcu_instr_fetch_if.sv
// Handshake and memory bus between the instruction fetch stage, the
// instruction memory and the decode/execute consumer.
interface gppcu_instr_fetch_if #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 10
);
    // Run control
    logic                iSTART;
    logic [ADDR_W:0]     iPROG_LEN;
    logic                iABORT;
    logic                oBUSY;
    logic                oDONE;

    // Instruction memory read port
    logic                oIMEM_RD;
    logic [ADDR_W-1:0]   oIMEM_ADDR;
    logic [INSTR_W-1:0]  iIMEM_DATA;

    // Instruction stream toward decode
    logic                oVALID;
    logic                iREADY;
    logic [INSTR_W-1:0]  oINSTR;
    logic [4:0]          oOPC;
    logic [ADDR_W-1:0]   oPC;

    // Fetch stage side
    modport slave (
        input  iSTART, iPROG_LEN, iABORT, iIMEM_DATA, iREADY,
        output oBUSY, oDONE, oIMEM_RD, oIMEM_ADDR, oVALID, oINSTR, oOPC, oPC
    );

    // Environment side: run controller, memory and consumer
    modport master (
        output iSTART, iPROG_LEN, iABORT, iIMEM_DATA, iREADY,
        input  oBUSY, oDONE, oIMEM_RD, oIMEM_ADDR, oVALID, oINSTR, oOPC, oPC
    );
endinterface

// File: rtl/gppcu_instr_fetch.sv
// Instruction fetch stage: walks instruction memory from address 0 for a
// programmed length, hides the one-cycle memory read latency behind a
// 2-entry prefetch queue and streams words to decode under valid/ready.
module gppcu_instr_fetch #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 10
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    gppcu_instr_fetch_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic                inflight_q, inflight_d;
    logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;

    logic [1:0]          count_q, count_d;
    logic [INSTR_W-1:0]  q0_instr_q, q0_instr_d;
    logic [INSTR_W-1:0]  q1_instr_q, q1_instr_d;
    logic [ADDR_W-1:0]   q0_pc_q, q0_pc_d;
    logic [ADDR_W-1:0]   q1_pc_q, q1_pc_d;

    logic                pop;
    logic                abort;
    logic                wr;
    logic                credit;
    logic                issue;
    logic [1:0]          cnt_after_pop;

    // Handshake, abort qualification and read-issue credit
    always_comb begin
        pop    = (count_q != 2'd0) && bus.iREADY;
        abort  = bus.iABORT && (state_q != S_IDLE);
        wr     = inflight_q && !abort;
        // A new read may only go out if its data is guaranteed a queue slot
        // once the current pop and the read already in flight are accounted.
        credit = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
        issue  = (state_q == S_FETCH) && !abort && credit;
    end

    // Run sequencer: next state, PC and remaining-count bookkeeping
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        remaining_d   = remaining_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;

        if (issue) begin
            inflight_pc_d = pc_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.iSTART) begin
                    pc_d        = '0;
                    remaining_d = bus.iPROG_LEN;
                    state_d     = (bus.iPROG_LEN != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    // PC wraps to 0 after the last address of a full-memory run.
                    pc_d        = pc_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W+1)'(1);
                    if (remaining_q == (ADDR_W+1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!inflight_q &&
                    ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any same-cycle start or completion.
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Prefetch queue: shift on pop, write returning data at the new tail
    always_comb begin
        q0_instr_d    = q0_instr_q;
        q0_pc_d       = q0_pc_q;
        q1_instr_d    = q1_instr_q;
        q1_pc_d       = q1_pc_q;
        count_d       = count_q;
        cnt_after_pop = count_q - {1'b0, pop};

        if (abort) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                q0_instr_d = q1_instr_q;
                q0_pc_d    = q1_pc_q;
            end
            if (wr) begin
                if (cnt_after_pop == 2'd0) begin
                    q0_instr_d = bus.iIMEM_DATA;
                    q0_pc_d    = inflight_pc_q;
                end else begin
                    q1_instr_d = bus.iIMEM_DATA;
                    q1_pc_d    = inflight_pc_q;
                end
            end
            count_d = cnt_after_pop + {1'b0, wr};
        end
    end

    // State and queue registers with asynchronous reset
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            remaining_q   <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            q0_instr_q    <= '0;
            q0_pc_q       <= '0;
            q1_instr_q    <= '0;
            q1_pc_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            remaining_q   <= remaining_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            q0_instr_q    <= q0_instr_d;
            q0_pc_q       <= q0_pc_d;
            q1_instr_q    <= q1_instr_d;
            q1_pc_q       <= q1_pc_d;
        end
    end

    assign bus.oIMEM_RD   = issue;
    assign bus.oIMEM_ADDR = issue ? pc_q : '0;
    assign bus.oVALID     = (count_q != 2'd0);
    assign bus.oINSTR     = q0_instr_q;
    assign bus.oOPC       = q0_instr_q[INSTR_W-1 -: 5];
    assign bus.oPC        = q0_pc_q;
    assign bus.oBUSY      = (state_q != S_IDLE);
    // An abort landing on the DONE cycle cancels the completion pulse.
    assign bus.oDONE      = (state_q == S_DONE) && !bus.iABORT;

endmodule

// File: tb/tb_gppcu_instr_fetch.sv
// Directed bench for gppcu_instr_fetch with a synchronous memory model and
// a scoreboard of expected {pc, instruction} transfers.
module tb_gppcu_instr_fetch;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 10;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;

    gppcu_instr_fetch_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) bus ();

    gppcu_instr_fetch #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    logic [INSTR_W-1:0] mem [0:(1<<ADDR_W)-1];
    int rd_cnt = 0;

    // Synchronous instruction memory: data appears the cycle after the strobe
    always @(posedge iCLK) begin
        if (bus.oIMEM_RD) begin
            bus.iIMEM_DATA <= mem[bus.oIMEM_ADDR];
            rd_cnt         <= rd_cnt + 1;
        end
    end

    int n_cmp = 0;
    int n_mis = 0;
    int acc_cnt = 0;
    int base_diff = 0;
    logic [ADDR_W+INSTR_W-1:0] sb [$];
    logic stall_chk = 1'b0;
    logic prev_stall = 1'b0;
    logic [INSTR_W-1:0] prev_instr = '0;
    logic [ADDR_W-1:0]  prev_pc = '0;

    function automatic logic [INSTR_W-1:0] word(input int i);
        return (INSTR_W'(i + 1) << 27) | INSTR_W'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input int len);
        for (int i = 0; i < len; i++) sb.push_back({ADDR_W'(i), word(i)});
    endtask

    // Per-cycle observation of the decode-side stream
    task automatic monitor();
        logic [ADDR_W+INSTR_W-1:0] e;
        if (stall_chk) begin
            chk("buffered_le2", 64'((rd_cnt - acc_cnt - base_diff) <= 2), 64'd1);
            if (prev_stall) begin
                chk("stall_instr", 64'(bus.oINSTR), 64'(prev_instr));
                chk("stall_pc", 64'(bus.oPC), 64'(prev_pc));
            end
            prev_stall = bus.oVALID && !bus.iREADY;
            prev_instr = bus.oINSTR;
            prev_pc    = bus.oPC;
        end
        if (bus.oVALID && bus.iREADY) begin
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("xfer_instr", 64'(bus.oINSTR), 64'(e[INSTR_W-1:0]));
                chk("xfer_opc", 64'(bus.oOPC), 64'(e[INSTR_W-1 -: 5]));
                chk("xfer_pc", 64'(bus.oPC), 64'(e[ADDR_W+INSTR_W-1:INSTR_W]));
            end
            acc_cnt++;
        end
    endtask

    // Inputs are applied at the falling edge, outputs observed just after
    task automatic drive(input logic s, input logic a, input logic r);
        bus.iSTART = s;
        bus.iABORT = a;
        bus.iREADY = r;
        #1;
        monitor();
    endtask

    task automatic adv();
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_valid"},  64'(bus.oVALID),     64'd0);
        chk({pfx, "_rd"},     64'(bus.oIMEM_RD),   64'd0);
        chk({pfx, "_addr"},   64'(bus.oIMEM_ADDR), 64'd0);
        chk({pfx, "_instr"},  64'(bus.oINSTR),     64'd0);
        chk({pfx, "_opc"},    64'(bus.oOPC),       64'd0);
        chk({pfx, "_pc"},     64'(bus.oPC),        64'd0);
        chk({pfx, "_busy"},   64'(bus.oBUSY),      64'd0);
        chk({pfx, "_done"},   64'(bus.oDONE),      64'd0);
    endtask

    initial begin
        int base_rd;
        int base_acc;
        int done_cnt;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = word(i);
        bus.iSTART    = 1'b0;
        bus.iABORT    = 1'b0;
        bus.iREADY    = 1'b0;
        bus.iPROG_LEN = '0;

        // Reset values
        repeat (2) @(negedge iCLK);
        #1;
        chk_all_zero("rst");
        iRST = 1'b0;
        @(negedge iCLK);

        // Len 4, consumer always ready
        base_rd = rd_cnt;
        bus.iPROG_LEN = 11'd4;
        push_run(4);
        drive(1'b1, 1'b0, 1'b1);
        adv();
        for (int c = 1; c <= 9; c++) begin
            drive(1'b0, 1'b0, 1'b1);
            chk("t4_valid", 64'(bus.oVALID), 64'(c >= 3 && c <= 6));
            chk("t4_done", 64'(bus.oDONE), 64'(c == 7));
            adv();
        end
        chk("t4_reads", 64'(rd_cnt - base_rd), 64'd4);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Len 5, ready pattern 1,0,0 repeating
        base_rd   = rd_cnt;
        base_acc  = acc_cnt;
        base_diff = rd_cnt - acc_cnt;
        bus.iPROG_LEN = 11'd5;
        push_run(5);
        prev_stall = 1'b0;
        stall_chk  = 1'b1;
        done_cnt   = 0;
        drive(1'b1, 1'b0, 1'b1);
        adv();
        for (int c = 1; c <= 30; c++) begin
            drive(1'b0, 1'b0, (c % 3) == 0);
            if (bus.oDONE) done_cnt++;
            adv();
        end
        stall_chk = 1'b0;
        chk("t5_done_pulses", 64'(done_cnt), 64'd1);
        chk("t5_accepted", 64'(acc_cnt - base_acc), 64'd5);
        chk("t5_reads", 64'(rd_cnt - base_rd), 64'd5);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);

        // Len 0: immediate completion, no reads
        base_rd = rd_cnt;
        bus.iPROG_LEN = 11'd0;
        drive(1'b1, 1'b0, 1'b1);
        adv();
        for (int c = 1; c <= 4; c++) begin
            drive(1'b0, 1'b0, 1'b1);
            chk("t0_done", 64'(bus.oDONE), 64'(c == 1));
            chk("t0_busy", 64'(bus.oBUSY), 64'(c == 1));
            chk("t0_valid", 64'(bus.oVALID), 64'd0);
            chk("t0_rd", 64'(bus.oIMEM_RD), 64'd0);
            adv();
        end
        chk("t0_reads", 64'(rd_cnt - base_rd), 64'd0);

        // Len 8 aborted in cycle 5, then a clean len 2 run
        base_acc = acc_cnt;
        bus.iPROG_LEN = 11'd8;
        push_run(8);
        drive(1'b1, 1'b0, 1'b1);
        adv();
        for (int c = 1; c <= 10; c++) begin
            drive(1'b0, c == 5, 1'b1);
            if (c == 6) begin
                chk("ab_valid", 64'(bus.oVALID), 64'd0);
                chk("ab_busy", 64'(bus.oBUSY), 64'd0);
            end
            chk("ab_no_done", 64'(bus.oDONE), 64'd0);
            adv();
        end
        chk("ab_accepted", 64'(acc_cnt - base_acc), 64'd3);
        sb.delete();

        base_rd = rd_cnt;
        bus.iPROG_LEN = 11'd2;
        push_run(2);
        drive(1'b1, 1'b0, 1'b1);
        adv();
        for (int c = 1; c <= 7; c++) begin
            drive(1'b0, 1'b0, 1'b1);
            if (c == 1) chk("re_addr0", 64'(bus.oIMEM_ADDR), 64'd0);
            if (c == 2) chk("re_addr1", 64'(bus.oIMEM_ADDR), 64'd1);
            chk("re_done", 64'(bus.oDONE), 64'(c == 5));
            adv();
        end
        chk("re_reads", 64'(rd_cnt - base_rd), 64'd2);
        chk("re_sb_empty", 64'(sb.size()), 64'd0);

        // Start while busy, then start+abort together
        bus.iPROG_LEN = 11'd6;
        drive(1'b1, 1'b0, 1'b0);
        adv();
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) bus.iPROG_LEN = 11'd3;
            drive(c == 2 || c == 4, c == 4, 1'b0);
            if (c == 3) begin
                chk("sb_busy_kept", 64'(bus.oBUSY), 64'd1);
                chk("sb_head_pc", 64'(bus.oPC), 64'd0);
            end
            if (c >= 5) begin
                chk("sa_busy", 64'(bus.oBUSY), 64'd0);
                chk("sa_valid", 64'(bus.oVALID), 64'd0);
                chk("sa_rd", 64'(bus.oIMEM_RD), 64'd0);
            end
            chk("sa_no_done", 64'(bus.oDONE), 64'd0);
            adv();
        end

        // Asynchronous reset with two words buffered
        bus.iPROG_LEN = 11'd8;
        drive(1'b1, 1'b0, 1'b0);
        adv();
        for (int c = 1; c <= 3; c++) begin
            drive(1'b0, 1'b0, 1'b0);
            adv();
        end
        drive(1'b0, 1'b0, 1'b0);
        chk("ar_pre_valid", 64'(bus.oVALID), 64'd1);
        chk("ar_pre_busy", 64'(bus.oBUSY), 64'd1);
        iRST = 1'b1;
        #1;
        chk_all_zero("ar");
        adv();
        iRST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b1);
            chk("ar_post_busy", 64'(bus.oBUSY), 64'd0);
            chk("ar_post_valid", 64'(bus.oVALID), 64'd0);
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/gppcu_instr_fetch.md
# gppcu_instr_fetch

Instruction fetch stage of the GPPCU, directly upstream of the combinational instruction decoder. On a start pulse it walks the instruction memory from address 0 for a programmed length, absorbs the one-cycle synchronous-memory read latency in a 2-entry prefetch queue, and presents one instruction per cycle to decode under a valid/ready handshake. Its 5-bit opcode output drives the decoder's opcode input directly.

## Interface
- INSTR_W, 32, instruction word width; opcode is bits [INSTR_W-1 -: 5]
- ADDR_W, 10, instruction memory address width
- iCLK  in  1  clock, all state on rising edge
- iRST  in  1  asynchronous, active-high reset
- iSTART  in  1  one-cycle pulse; latches iPROG_LEN and begins fetch at address 0
- iPROG_LEN  in  ADDR_W+1  number of instructions to fetch, 0..2^ADDR_W
- iABORT  in  1  one-cycle pulse; terminates the current run
- oIMEM_RD  out  1  instruction memory read strobe
- oIMEM_ADDR  out  ADDR_W  read address; meaningful only while oIMEM_RD=1
- iIMEM_DATA  in  INSTR_W  read data; valid in the cycle after the oIMEM_RD cycle
- oVALID  out  1  oINSTR/oOPC/oPC hold a valid instruction
- iREADY  in  1  decode/execute accepts the instruction; transfer when oVALID&iREADY
- oINSTR  out  INSTR_W  full instruction word at queue head
- oOPC  out  5  opcode field of oINSTR, to decoder
- oPC  out  ADDR_W  address oINSTR was fetched from
- oBUSY  out  1  high in any state other than IDLE
- oDONE  out  1  one-cycle pulse when the run completes normally

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: iSTART -> PC<=0, remaining<=iPROG_LEN; next state FETCH if iPROG_LEN>0, else DONE. iABORT ignored in IDLE.
- FETCH: oIMEM_RD=1, oIMEM_ADDR=PC when issue is allowed: (count + inflight - pop) < 2, where count = queue occupancy (0..2), inflight = read issued last cycle (0/1), pop = oVALID&iREADY. Each issue: PC+1, remaining-1. When the issue that makes remaining 0 occurs -> DRAIN.
- Returning data (cycle after issue) is written to queue tail with its address; the credit rule guarantees the queue never overflows; write and pop in the same cycle are both honoured.
- DRAIN: no reads. When inflight=0 and (count=0, or count=1 with pop) -> DONE.
- DONE: oDONE=1 for exactly one cycle, then IDLE.
- iABORT in FETCH/DRAIN/DONE: next cycle IDLE, queue flushed (oVALID=0), inflight read data dropped, no oDONE. Abort wins over a same-cycle iSTART and over a same-cycle pop (the pop still counts as accepted by downstream).
- iSTART while oBUSY=1: ignored.
- PC is ADDR_W bits; with iPROG_LEN=2^ADDR_W the final issue is address 2^ADDR_W-1 and PC wraps to 0 unused.
- oOPC is purely oINSTR[INSTR_W-1 -: 5]; no decoding in this block.

## Timing
- Reset: state IDLE, count=0, inflight=0, PC=0; oVALID=0, oIMEM_RD=0, oIMEM_ADDR=0, oINSTR=0, oOPC=0, oPC=0, oBUSY=0, oDONE=0.
- iSTART sampled at edge E0; FETCH in cycle 1 with read of address 0; data on iIMEM_DATA in cycle 2; oVALID=1 in cycle 3 (start-to-first-valid = 3 cycles).
- With iREADY held high: one instruction per cycle sustained, no bubbles after the first.
- iREADY low: at most 2 instructions buffered; reads stop until credit frees; oINSTR/oOPC/oPC stable while oVALID&!iREADY.
- oDONE asserted the cycle after the last instruction's handshake cycle (in DONE state); for iPROG_LEN=0, cycle 1 after start.
- Queue outputs registered; oVALID = (count!=0).

## Test plan
- Reset mid-FETCH with count=2: assert iRST -> all outputs 0 immediately (asynchronous), state IDLE after release.
- iPROG_LEN=4, memory[i]=(opcode i+1)<<27|i, iREADY=1 -> oVALID cycles 3..6, oOPC 1,2,3,4, oPC 0..3, oDONE in cycle 7, exactly 4 reads.
- iPROG_LEN=5, iREADY toggling 1,0,0,1,... -> all 5 words delivered in order, none duplicated/lost, never more than 2 buffered, oINSTR stable while stalled.
- iPROG_LEN=0 -> no oIMEM_RD, oVALID never high, oDONE pulse cycle 1.
- iPROG_LEN=8, iABORT in cycle 5 -> cycle 6 oVALID=0, oBUSY=0, no oDONE; next iSTART with iPROG_LEN=2 fetches address 0 and 1 cleanly.
- iSTART pulsed again while busy and iSTART+iABORT same cycle -> both starts ignored; run aborted.
